// File: rtl/mcycle_datapath.sv
// Iterative multiply/divide datapath for the MCycle unit.
// Operands are latched as magnitudes on Init, one shift-add (multiply) or
// restoring shift-subtract (divide) step runs per accepted Shift, and Write
// commits the sign-corrected accumulator to the result registers.
module mcycle_datapath #(
  parameter int width = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Init,
  input  logic             Shift,
  input  logic             Write,
  input  logic             MCycleOp,
  input  logic             Signed,
  input  logic [width-1:0] Operand1,
  input  logic [width-1:0] Operand2,
  output logic [width-1:0] Result1,
  output logic [width-1:0] Result2,
  output logic             DivByZero,
  output logic             Ready
);

  localparam int             CW    = $clog2(width + 1);
  localparam logic [CW-1:0]  STEPS = CW'(width);

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  // Latched operation context
  op_e              op_q;
  logic             neg_res;
  logic             neg_rem;
  logic             div_zero;
  logic [width-1:0] opnd;          // multiplicand (mul) or divisor (div) magnitude
  logic [width-1:0] dividend_raw;  // original dividend for the divide-by-zero result

  // Accumulator: {hi, lo} = product (mul) or {remainder, quotient} (div)
  logic [width-1:0] hi;
  logic [width-1:0] lo;
  logic [CW-1:0]    count;

  // Operand magnitudes at Init
  logic [width-1:0] op1_mag;
  logic [width-1:0] op2_mag;

  // Next accumulator value for one iteration step
  logic [width-1:0] hi_step;
  logic [width-1:0] lo_step;
  logic [width:0]   mul_sum;
  logic [width:0]   rem_shift;
  logic [width:0]   rem_diff;
  logic             rem_ge;

  // Sign-corrected commit values
  logic [2*width-1:0] prod_c;
  logic [width-1:0]   r1_next;
  logic [width-1:0]   r2_next;

  logic step_ok;

  assign Ready   = (count == STEPS);
  // Shifts after the final step (e.g. the controller's extra divide cycle) are ignored.
  assign step_ok = Shift && !Ready;

  assign op1_mag = (Signed && Operand1[width-1]) ? -Operand1 : Operand1;
  assign op2_mag = (Signed && Operand2[width-1]) ? -Operand2 : Operand2;

  // Combinational single-step datapath for both multiply and divide
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    hi_step   = hi;
    lo_step   = lo;
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    // The shifted remainder needs one extra bit: it can reach 2*divisor-1.
    rem_shift = {hi, lo[width-1]};
    rem_diff  = rem_shift - {1'b0, opnd};
    rem_ge    = (rem_shift >= {1'b0, opnd});
    if (op_q == OP_MUL) begin
      // Add-then-shift of {carry, hi, lo} right by one.
      hi_step = mul_sum[width:1];
      lo_step = {mul_sum[0], lo[width-1:1]};
    end else begin
      hi_step = rem_ge ? rem_diff[width-1:0] : rem_shift[width-1:0];
      lo_step = {lo[width-2:0], rem_ge};
    end
  end

  // Sign correction of the current accumulator for commit
  always_comb begin
    prod_c  = neg_res ? -{hi, lo} : {hi, lo};
    r1_next = prod_c[width-1:0];
    r2_next = prod_c[2*width-1:width];
    if (op_q == OP_DIV) begin
      if (div_zero) begin
        r1_next = '1;
        r2_next = dividend_raw;
      end else begin
        r1_next = neg_res ? -lo : lo;
        r2_next = neg_rem ? -hi : hi;
      end
    end
  end

  // Operand latch, accumulator and step counter
  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    // NOTE: all state is reset here, including the accumulator, so an aborted op leaves nothing behind.
    if (!Reset) begin
      op_q         <= OP_MUL;
      neg_res      <= 1'b0;
      neg_rem      <= 1'b0;
      div_zero     <= 1'b0;
      opnd         <= '0;
      dividend_raw <= '0;
      hi           <= '0;
      lo           <= '0;
      count        <= '0;
    end else if (Init) begin
      op_q         <= op_e'(MCycleOp);
      neg_res      <= Signed && (Operand1[width-1] ^ Operand2[width-1]);
      neg_rem      <= Signed && Operand1[width-1];
      div_zero     <= MCycleOp && (Operand2 == '0);
      dividend_raw <= Operand1;
      hi           <= '0;
      count        <= '0;
      if (MCycleOp) begin
        lo   <= op1_mag;
        opnd <= op2_mag;
      end else begin
        lo   <= op2_mag;
        opnd <= op1_mag;
      end
    end else if (step_ok) begin
      hi    <= hi_step;
      lo    <= lo_step;
      count <= count + CW'(1);
    end
  end

  // Result registers, updated only on Write
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      Result1   <= '0;
      Result2   <= '0;
      DivByZero <= 1'b0;
    end else if (Write) begin
      Result1   <= r1_next;
      Result2   <= r2_next;
      DivByZero <= div_zero;
    end
  end

endmodule

// File: doc/mcycle_datapath.md
# mcycle_datapath

Iterative multiply/divide datapath driven by the multi-cycle control FSM. It latches operands on `Init` and performs one shift-add (multiply) or shift-subtract (divide) step per cycle in which `Shift` is high. On `Write` it commits the sign-corrected results to the output registers. It sits directly downstream of the controller in the MCycle unit, and its outputs feed the register-file writeback mux.

## Interface
- `width`, default 32: operand width in bits; also sets step counts.
- `CLK`  in  1  clock; all state updates on rising edge.
- `Reset`  in  1  synchronous, active-low reset; sampled on rising edge of `CLK`.
- `Init`  in  1  from controller; load operands, clear accumulator and step counter.
- `Shift`  in  1  from controller; perform one iteration step.
- `Write`  in  1  from controller; commit results to `Result1`/`Result2`.
- `MCycleOp`  in  1  0 = multiply, 1 = divide; sampled only on `Init`.
- `Signed`  in  1  1 = two's-complement operands; sampled only on `Init`.
- `Operand1`  in  `width`  multiplicand / dividend; sampled only on `Init`.
- `Operand2`  in  `width`  multiplier / divisor; sampled only on `Init`.
- `Result1`  out  `width`  product low half / quotient (registered).
- `Result2`  out  `width`  product high half / remainder (registered).
- `DivByZero`  out  1  set on `Write` of a divide with zero divisor (registered).
- `Ready`  out  1  high when all required steps for the latched op are done.

## Operation
- Sign handling:
  - On `Init` with `Signed`=1, operands are stored as magnitudes.
  - Flags are latched: `neg_res` (multiply: sign1 XOR sign2; divide quotient: same) and `neg_rem` (sign of dividend).
  - With `Signed`=0 both flags are 0.
- Multiply:
  - Accumulator `{hi, lo}` is 2*`width` bits; `lo` is loaded with the multiplier magnitude.
  - Each step: if `lo[0]`, `hi` += multiplicand with a carry bit; then the whole `{carry, hi, lo}` shifts right by 1.
  - Requires exactly `width` steps.
- Divide (restoring):
  - `{rem, quo}` is loaded with `{0, dividend}`.
  - Each step: shift left by 1; if `rem` >= divisor, `rem` -= divisor and `quo[0]` = 1.
  - Requires `width` steps. The controller issues `width`+1 `Shift` cycles for divide; the extra one is ignored.
- Step counter:
  - 0..`width`; incremented only on accepted steps.
  - Any `Shift` with counter == `width` is ignored; state holds.
  - `Ready` = (counter == `width`).
- Commit on `Write`:
  - `Result1`/`Result2` get the current accumulator, sign-corrected.
  - Multiply: 2*`width` negate of `{hi, lo}` if `neg_res`.
  - Divide: quotient negated if `neg_res`; remainder negated if `neg_rem`.
- Divide by zero (divisor == 0 latched at `Init`): `Write` commits `Result1` = all ones, `Result2` = original signed dividend, `DivByZero` = 1. Otherwise `Write` clears `DivByZero`.
- Operand or mode changes after `Init` have no effect until the next `Init`.
- Outputs hold between `Write`s.

## Timing
- Reset (`Reset`=0 at an edge): `Result1`=0, `Result2`=0, `DivByZero`=0, `Ready`=0, accumulator/flags/counter=0. Reset overrides all other inputs.
- Priority at a clock edge: Reset > `Init` > `Shift`. `Init` and `Shift` in the same cycle: load only, no step.
- `Init` at edge N: operands visible in the accumulator after N; first step at the first subsequent edge with `Shift`=1.
- Latency: result is valid `width` `Shift` cycles after `Init`; `Ready` rises the cycle after the `width`-th step edge.
- `Write` and `Shift` in the same cycle: commit uses the pre-step accumulator, and the step still occurs.
- `Write` while `Ready`=0 commits the partial value; this is legal but not meaningful.
- `Init` mid-operation restarts cleanly from new operands.
- Reset mid-operation aborts; the next op needs `Init`.

## Test plan
- `width`=8, unsigned multiply 13×11: `Init`, 8 `Shift`, `Write` -> `Result1`=0x8F, `Result2`=0x00, `Ready`=1.
- `width`=8, signed multiply -3×5 -> `Result1`=0xF1, `Result2`=0xFF; signed -128×-128 -> `Result1`=0x00, `Result2`=0x40.
- `width`=8, unsigned divide 100/7 with 9 `Shift` (extra ignored) -> `Result1`=14, `Result2`=2; signed -7/2 -> `Result1`=0xFD, `Result2`=0xFF.
- Divide 55/0 -> `Result1`=0xFF, `Result2`=55, `DivByZero`=1; a following valid divide clears `DivByZero` to 0.
- `Reset`=0 after 3 steps of a multiply -> all outputs 0 next cycle, `Ready`=0. A fresh `Init` plus 8 steps gives the correct product.
- `Init`+`Shift` in the same cycle, then 8 `Shift`: the result equals the normal case; counter reaches 8, not 9. `Write`+`Shift` in the same cycle commits the pre-step value.
